branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: Clk, Reset.
REQ-002 Ports SHALL be (name direction width meaning):
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- Start  in  1  program launch request, level
- Instr  in  9  instruction word fetched at ProgCtr
- ProgCtr  in  10  current program counter
- LutWrEn  in  1  branch-target table write strobe
- LutWrAddr  in  4  table write index
- LutWrData  in  10  table write data, absolute address
- BranchAbsEn  out  1  absolute branch request to program counter
- BranchRelEn  out  1  relative branch request to program counter
- AbsTarget  out  10  absolute target
- RelTarget  out  6  relative offset
- Running  out  1  high in RUN
- Done  out  1  high in HALTED
- InstrCount  out  16  instructions retired in current run

Function
REQ-003 The block SHALL have FSM states IDLE, ARMED, RUN and HALTED.
REQ-004 State transitions SHALL be:
- IDLE->ARMED when Start=1
- ARMED->RUN when Start=0
- RUN->HALTED on a decoded HALT
- HALTED->ARMED when Start=1
- all other cases hold state
REQ-005 Start SHALL be ignored in RUN.
REQ-006 Decode SHALL be combinational from Instr, valid only in RUN:
- Instr[8:7]=2'b11, Instr[6]=0: relative branch; BranchRelEn=1, RelTarget=Instr[5:0]
- Instr[8:7]=2'b11, Instr[6:5]=2'b10: absolute branch; BranchAbsEn=1, AbsTarget=LUT[Instr[3:0]]
- Instr[8:7]=2'b11, Instr[6:5]=2'b11: HALT
- anything else: non-branch; both enables 0
REQ-007 Branch outputs SHALL be zero-latency, so that the program counter's next update in the same cycle uses them.
REQ-008 The branch condition (ALU flag) SHALL NOT be evaluated here; the program counter gates relative branches.
REQ-009 On the HALT cycle and throughout HALTED, the block SHALL drive BranchAbsEn=1 and AbsTarget=ProgCtr, so the program counter self-loops.
REQ-010 In IDLE and ARMED, BranchAbsEn=BranchRelEn=0, and AbsTarget and RelTarget SHALL be 0.
REQ-011 BranchAbsEn and BranchRelEn SHALL never be high together.
REQ-012 LUT writes SHALL take effect at the clock edge, only when LutWrEn=1 and the state is IDLE or HALTED; writes in ARMED or RUN SHALL be dropped.
REQ-013 A LUT read of the index being written SHALL return the old value in that cycle.
REQ-014 InstrCount SHALL increment by 1 every RUN cycle, including the HALT cycle, and SHALL saturate at 16'hFFFF.
REQ-015 InstrCount SHALL clear on entry to ARMED and SHALL hold its value in HALTED.
REQ-016 Running SHALL be registered state decode: 1 exactly in RUN.
REQ-017 Done SHALL be registered state decode: 1 exactly in HALTED.

Reset
REQ-018 Reset SHALL take priority over all inputs, including Start and LutWrEn.
REQ-019 Reset SHALL set the state to IDLE, all 16 LUT entries to 0, InstrCount to 0, and Running and Done to 0.
REQ-020 Reset asserted mid-RUN SHALL deassert both branch enables in the following cycle.

Structure
REQ-021 A shared package branch_pkg SHALL hold:
- the state enum
- the Instr field constants: branch class 2'b11, ABS 2'b10, HALT 2'b11
- the width parameters: PC=10, REL=6, LUT_IDX=4
REQ-022 The 16x10 table SHALL be the sub-module branch_lut, with one synchronous write port and one asynchronous read port.
REQ-023 The remaining logic (FSM, decode, counter) SHALL reside in branch_ctrl.

Verification
REQ-024 Reset, then Start high 1 cycle, then low -> Running=1 on the second edge after Start, and branch enables 0 during ARMED.
REQ-025 In IDLE, write LUT[3]=10'd200; in RUN, apply Instr=9'b1_1100_0011 -> BranchAbsEn=1, AbsTarget=200 in the same cycle.
REQ-026 In RUN, Instr=9'b1_1000_0101 -> BranchRelEn=1, RelTarget=5, BranchAbsEn=0.
REQ-027 In RUN, Instr=9'b1_1110_0000 with ProgCtr=17 -> next cycle Done=1, Running=0, BranchAbsEn=1, AbsTarget=17; InstrCount equals the RUN cycle count.
REQ-028 LutWrEn in RUN to index 3 with data 9 -> LUT[3] stays 200. Then Start in HALTED -> ARMED, InstrCount=0, Done=0.
REQ-029 Reset asserted during RUN -> IDLE next cycle, LUT[3] reads 0, all outputs 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: FSM states, instruction
// field encodings, decode classes and datapath widths.
package branch_pkg;

    localparam int PC_W      = 10;
    localparam int REL_W     = 6;
    localparam int LUT_IDX_W = 4;
    localparam int LUT_DEPTH = 1 << LUT_IDX_W;
    localparam int INSTR_W   = 9;
    localparam int CNT_W     = 16;

    // Instr[8:7] selects the branch class; Instr[6:5] selects the operation within it.
    localparam logic [1:0] CLASS_BRANCH = 2'b11;
    localparam logic [1:0] OP_ABS       = 2'b10;
    localparam logic [1:0] OP_HALT      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_REL,
        DEC_ABS,
        DEC_HALT
    } decode_e;

    function automatic decode_e decode_instr(input logic [INSTR_W-1:0] instr);
        decode_e cls;
        cls = DEC_NONE;
        if (instr[8:7] == CLASS_BRANCH) begin
            if (!instr[6]) begin
                cls = DEC_REL;
            end else if (instr[6:5] == OP_ABS) begin
                cls = DEC_ABS;
            end else if (instr[6:5] == OP_HALT) begin
                cls = DEC_HALT;
            end
        end
        return cls;
    endfunction

endpackage : branch_pkg

// File: rtl/branch_lut.sv
// 16-entry absolute branch-target table: one synchronous write port and one
// asynchronous read port, so a read of the entry being written returns the old value.
module branch_lut
    import branch_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 wr_en,
    input  logic [LUT_IDX_W-1:0] wr_addr,
    input  logic [PC_W-1:0]      wr_data,
    input  logic [LUT_IDX_W-1:0] rd_addr,
    output logic [PC_W-1:0]      rd_data
);

    logic [PC_W-1:0] mem_q [LUT_DEPTH];
    logic [PC_W-1:0] mem_d [LUT_DEPTH];

    // NOTE: every variable assigned in always_comb gets a full default first, so no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // NOTE: this table is cleared by reset because software relies on unwritten
    // entries reading 0; a plain storage array would normally be left unreset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : branch_lut

// File: rtl/branch_ctrl.sv
// Program-sequencing controller: launch FSM, zero-latency branch decode driving
// the program counter, and a saturating retired-instruction counter.
module branch_ctrl
    import branch_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [INSTR_W-1:0]   Instr,
    input  logic [PC_W-1:0]      ProgCtr,
    input  logic                 LutWrEn,
    input  logic [LUT_IDX_W-1:0] LutWrAddr,
    input  logic [PC_W-1:0]      LutWrData,
    output logic                 BranchAbsEn,
    output logic                 BranchRelEn,
    output logic [PC_W-1:0]      AbsTarget,
    output logic [REL_W-1:0]     RelTarget,
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_W-1:0]     InstrCount
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    decode_e           dec;
    logic              lut_wr_en;
    logic [PC_W-1:0]   lut_rd_data;

    // The table may only change while no program is executing from it.
    assign lut_wr_en = LutWrEn && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

    branch_lut u_lut (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (lut_wr_en),
        .wr_addr (LutWrAddr),
        .wr_data (LutWrData),
        .rd_addr (Instr[LUT_IDX_W-1:0]),
        .rd_data (lut_rd_data)
    );

    assign dec = decode_instr(Instr);

    always_comb begin
        state_d     = state_q;
        BranchAbsEn = 1'b0;
        BranchRelEn = 1'b0;
        AbsTarget   = '0;
        RelTarget   = '0;

        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!Start) state_d = ST_RUN;
            end
            ST_RUN: begin
                case (dec)
                    DEC_REL: begin
                        BranchRelEn = 1'b1;
                        RelTarget   = Instr[REL_W-1:0];
                    end
                    DEC_ABS: begin
                        BranchAbsEn = 1'b1;
                        AbsTarget   = lut_rd_data;
                    end
                    DEC_HALT: begin
                        // Self-loop the program counter from the HALT cycle onward.
                        BranchAbsEn = 1'b1;
                        AbsTarget   = ProgCtr;
                        state_d     = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: begin
                BranchAbsEn = 1'b1;
                AbsTarget   = ProgCtr;
                if (Start) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if ((state_q == ST_RUN) && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
        if ((state_d == ST_ARMED) && (state_q != ST_ARMED)) begin
            count_d = '0;
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign Running    = running_q;
    assign Done       = done_q;
    assign InstrCount = count_q;

endmodule : branch_ctrl

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl: launch sequence, branch decode,
// LUT write gating, HALT self-loop, restart, mid-run reset and counter saturation.
module tb_branch_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instr;
    logic [9:0]  ProgCtr;
    logic        LutWrEn;
    logic [3:0]  LutWrAddr;
    logic [9:0]  LutWrData;
    logic        BranchAbsEn;
    logic        BranchRelEn;
    logic [9:0]  AbsTarget;
    logic [5:0]  RelTarget;
    logic        Running;
    logic        Done;
    logic [15:0] InstrCount;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [8:0] I_ABS3  = 9'b1_1100_0011;
    localparam logic [8:0] I_ABS5  = 9'b1_1100_0101;
    localparam logic [8:0] I_REL5  = 9'b1_1000_0101;
    localparam logic [8:0] I_REL63 = 9'b1_1011_1111;
    localparam logic [8:0] I_HALT  = 9'b1_1110_0000;
    localparam logic [8:0] I_NOP   = 9'b0_1110_0000;

    branch_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Instr       (Instr),
        .ProgCtr     (ProgCtr),
        .LutWrEn     (LutWrEn),
        .LutWrAddr   (LutWrAddr),
        .LutWrData   (LutWrData),
        .BranchAbsEn (BranchAbsEn),
        .BranchRelEn (BranchRelEn),
        .AbsTarget   (AbsTarget),
        .RelTarget   (RelTarget),
        .Running     (Running),
        .Done        (Done),
        .InstrCount  (InstrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Observed outputs packed as {abs_en, rel_en, abs_tgt, rel_tgt, running, done, count}.
    logic [35:0] obs;
    assign obs = {BranchAbsEn, BranchRelEn, AbsTarget, RelTarget, Running, Done, InstrCount};

    function automatic logic [35:0] ev(input logic ae, input logic re, input logic [9:0] at,
                                       input logic [5:0] rt, input logic run, input logic dn,
                                       input logic [15:0] cnt);
        return {ae, re, at, rt, run, dn, cnt};
    endfunction

    // Inputs change 1 ns after the edge; outputs are sampled 2 ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] e;
        Reset = 1'b1; Start = 1'b0; Instr = I_HALT; ProgCtr = 10'd33;
        LutWrEn = 1'b0; LutWrAddr = '0; LutWrData = '0;
        tick(); tick();
        Reset = 1'b0;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 0, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
    endtask

    task automatic test_lut_write_idle();
        Instr = I_NOP;
        LutWrEn = 1'b1; LutWrAddr = 4'd3; LutWrData = 10'd200;
        tick();
        LutWrAddr = 4'd5; LutWrData = 10'd1023;
        tick();
        LutWrEn = 1'b0;
    endtask

    task automatic test_launch();
        logic [35:0] e;
        Start = 1'b1; Instr = I_ABS3;
        tick();
        Start = 1'b0;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 0, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL armed_quiet: got %h expected %h", obs, e); end
        tick();
        settle();
        e = ev(1, 0, 10'd200, 6'd0, 1, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL run_entry_abs3: got %h expected %h", obs, e); end
    endtask

    task automatic test_decode();
        logic [35:0] e;
        Instr = I_ABS5;
        settle();
        e = ev(1, 0, 10'd1023, 6'd0, 1, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL abs5_max: got %h expected %h", obs, e); end
        tick();
        Instr = I_REL5;
        settle();
        e = ev(0, 1, 10'd0, 6'd5, 1, 0, 16'd1);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL rel5: got %h expected %h", obs, e); end
        tick();
        Instr = I_REL63;
        settle();
        e = ev(0, 1, 10'd0, 6'd63, 1, 0, 16'd2);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL rel63: got %h expected %h", obs, e); end
        tick();
        Instr = I_NOP; Start = 1'b1;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 1, 0, 16'd3);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL nonbranch: got %h expected %h", obs, e); end
        tick();
        Start = 1'b0;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 1, 0, 16'd4);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL start_ignored_in_run: got %h expected %h", obs, e); end
    endtask

    task automatic test_lut_write_run();
        logic [35:0] e;
        LutWrEn = 1'b1; LutWrAddr = 4'd3; LutWrData = 10'd9;
        tick();
        LutWrEn = 1'b0; Instr = I_ABS3;
        settle();
        e = ev(1, 0, 10'd200, 6'd0, 1, 0, 16'd5);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL run_write_dropped: got %h expected %h", obs, e); end
    endtask

    task automatic test_halt();
        logic [35:0] e;
        Instr = I_HALT; ProgCtr = 10'd17;
        settle();
        e = ev(1, 0, 10'd17, 6'd0, 1, 0, 16'd5);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL halt_cycle: got %h expected %h", obs, e); end
        tick();
        Instr = I_REL5;
        settle();
        e = ev(1, 0, 10'd17, 6'd0, 0, 1, 16'd6);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL halted_loop: got %h expected %h", obs, e); end
        tick(); tick();
        ProgCtr = 10'd18;
        settle();
        e = ev(1, 0, 10'd18, 6'd0, 0, 1, 16'd6);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL halted_hold: got %h expected %h", obs, e); end
    endtask

    task automatic test_restart();
        logic [35:0] e;
        LutWrEn = 1'b1; LutWrAddr = 4'd3; LutWrData = 10'd9;
        tick();
        LutWrEn = 1'b0; Start = 1'b1;
        tick();
        Instr = I_ABS3;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 0, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL restart_armed: got %h expected %h", obs, e); end
        Start = 1'b0;
        tick(); tick();
        settle();
        e = ev(1, 0, 10'd9, 6'd0, 1, 0, 16'd1);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL halted_write_taken: got %h expected %h", obs, e); end
    endtask

    task automatic test_reset_mid_run();
        logic [35:0] e;
        Reset = 1'b1; Start = 1'b1;
        LutWrEn = 1'b1; LutWrAddr = 4'd3; LutWrData = 10'd77;
        tick();
        Reset = 1'b0; Start = 1'b0; LutWrEn = 1'b0;
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 0, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL reset_mid_run: got %h expected %h", obs, e); end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        settle();
        e = ev(1, 0, 10'd0, 6'd0, 1, 0, 16'd0);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL lut_cleared: got %h expected %h", obs, e); end
    endtask

    task automatic test_saturation();
        logic [35:0] e;
        Instr = I_NOP;
        for (int i = 0; i < 65534; i++) tick();
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 1, 0, 16'hFFFE);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL count_near_max: got %h expected %h", obs, e); end
        tick(); tick(); tick();
        settle();
        e = ev(0, 0, 10'd0, 6'd0, 1, 0, 16'hFFFF);
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL count_saturate: got %h expected %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_lut_write_idle();
        test_launch();
        test_decode();
        test_lut_write_run();
        test_halt();
        test_restart();
        test_reset_mid_run();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_branch_ctrl
